icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped, read-only instruction cache between the instruction fetcher and mem_ctrler.
//  Serves 32-bit instruction reads from the fetcher. On a miss it acts as the requester on the
//  mem_ctrler icache port: valid/addr out, ready pulse plus 16-byte line back. It then fills
//  the line and returns the requested word.
// PARAMETERS
//  INDEX_BITS  6   log2(number of lines); 64 lines x 16 B = 1 KiB
//  OFFSET_BITS 4   log2(line bytes); fixed at 4 (128-bit line), not to be overridden
//  TAG_BITS    32-INDEX_BITS-OFFSET_BITS (derived localparam, 22 by default)
// PORTS
//  clk                   in   1    clock
//  rst                   in   1    reset; synchronous, active-high
//  rdy                   in   1    global enable; when 0 the block freezes
//  valid_from_fetcher    in   1    fetch request; held until ready_to_fetcher seen
//  addr_from_fetcher     in   32   instruction byte address; [1:0] ignored
//  ready_to_fetcher      out  1    one-cycle pulse: inst_to_fetcher valid
//  inst_to_fetcher       out  32   fetched instruction
//  valid_to_mem_ctrler   out  1    line-fill request
//  addr_to_mem_ctrler    out  32   line address {tag,index,4'b0}
//  ready_from_mem_ctrler in   1    one-cycle pulse: data_from_mem_ctrler holds the line
//  data_from_mem_ctrler  in   128  line data, byte k at [8k+7:8k] (little-endian)
// BEHAVIOUR
//  Clock and reset are decided: single clock clk; reset rst is synchronous and active-high.
//  Reset: all line valid bits 0; state IDLE; ready_to_fetcher=0; valid_to_mem_ctrler=0;
//   inst_to_fetcher=0; addr_to_mem_ctrler=0. Tag/data arrays are not reset.
//  rdy=0, rst=0: no register changes, outputs hold; ready pulses are stretched.
//  All outputs are registered.
//  Address split: tag=addr[31:32-TAG_BITS], index=addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS],
//   word=addr[3:2]; word w = line[32w+31:32w].
//  FSM IDLE:
//   - valid_from_fetcher is ignored while ready_to_fetcher=1 (the fetcher is still dropping valid).
//   - Else, if valid_from_fetcher=1: latch the address into req_addr.
//   - Hit (line valid, tag match): next cycle ready_to_fetcher=1 with the selected word. Stay IDLE.
//     Hit latency is 1 cycle.
//   - Miss: next cycle valid_to_mem_ctrler=1, addr_to_mem_ctrler={tag,index,4'b0}. Go to MISS.
//  FSM MISS:
//   - valid_to_mem_ctrler and addr_to_mem_ctrler are held stable until ready_from_mem_ctrler=1
//     is sampled.
//   - In that cycle:
//     - write data, tag and valid bit at the req_addr index;
//     - valid_to_mem_ctrler<=0;
//     - ready_to_fetcher<=1 with inst = word req_addr[3:2] of data_from_mem_ctrler (the
//       incoming line, not the array);
//     - go to IDLE.
//   - Miss penalty = mem_ctrler latency + 1 cycle.
//  ready_to_fetcher is always a single-cycle pulse (rdy=1). ready_from_mem_ctrler is
//   ignored outside MISS.
//  valid_to_mem_ctrler is still 1 during the ready_from_mem_ctrler cycle. mem_ctrler
//   blocks re-acceptance from the same requester in that cycle, and valid is 0 the cycle after.
//  Changes on addr_from_fetcher during MISS have no effect; req_addr governs fill and response.
//  Conflict miss overwrites the resident line unconditionally; the cache is read-only, no writeback.
//  Reset mid-MISS: the request is abandoned and the line is not filled. mem_ctrler shares rst
//   and aborts too.
// TESTING
//  1 Reset, fetch 0x0000_1004 -> miss; valid_to_mem_ctrler=1, addr_to_mem_ctrler=0x0000_1000
//    stable until ready; line 0x..._DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA -> inst 0xBBBBBBBB,
//    1 cycle after ready
//  2 Then fetch 0x0000_1008 -> hit; ready_to_fetcher 1 cycle after request; inst 0xCCCCCCCC;
//    no mem request
//  3 Fetch 0x0000_1400 (same index 0, new tag) -> miss and refill; then 0x0000_1004 misses again
//  4 rdy=0 for 5 cycles during MISS and during a hit pulse -> outputs frozen; pulse completes after
//    rdy=1; exactly one response per request
//  5 rst at MISS cycle 3 -> next cycle valid_to_mem_ctrler=0, ready_to_fetcher=0; refetch
//    0x0000_1004 misses
//  6 valid_from_fetcher held high through the ready pulse -> no duplicate response; back-to-back
//    hits yield one pulse per request

Source files
------------

// File: rtl/icache_if.sv
// rtl/icache_if.sv - fetcher and mem_ctrler handshake bundle for the instruction cache
interface icache_if;
    logic         valid_from_fetcher;
    logic [31:0]  addr_from_fetcher;
    logic         ready_to_fetcher;
    logic [31:0]  inst_to_fetcher;
    logic         valid_to_mem_ctrler;
    logic [31:0]  addr_to_mem_ctrler;
    logic         ready_from_mem_ctrler;
    logic [127:0] data_from_mem_ctrler;

    modport slave (
        input  valid_from_fetcher, addr_from_fetcher,
        input  ready_from_mem_ctrler, data_from_mem_ctrler,
        output ready_to_fetcher, inst_to_fetcher,
        output valid_to_mem_ctrler, addr_to_mem_ctrler
    );

    modport master (
        output valid_from_fetcher, addr_from_fetcher,
        output ready_from_mem_ctrler, data_from_mem_ctrler,
        input  ready_to_fetcher, inst_to_fetcher,
        input  valid_to_mem_ctrler, addr_to_mem_ctrler
    );
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache with single-line refill from mem_ctrler
module icache #(
    parameter int INDEX_BITS  = 6,
    parameter int OFFSET_BITS = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    icache_if.slave  bus
);
    localparam int TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic {IDLE, MISS} state_t;

    state_t                state;
    logic [31:0]           req_addr;
    logic [LINES-1:0]      valid_bits;
    logic [TAG_BITS-1:0]   tag_arr  [LINES];
    logic [127:0]          data_arr [LINES];

    logic [TAG_BITS-1:0]   in_tag, req_tag;
    logic [INDEX_BITS-1:0] in_idx, req_idx;
    logic [1:0]            in_word, req_word;
    logic [127:0]          hit_line;
    logic                  hit;
    logic                  fill_en;
    logic                  unused_addr_bits;

    assign in_tag   = bus.addr_from_fetcher[31 -: TAG_BITS];
    assign in_idx   = bus.addr_from_fetcher[OFFSET_BITS +: INDEX_BITS];
    assign in_word  = bus.addr_from_fetcher[3:2];
    assign req_tag  = req_addr[31 -: TAG_BITS];
    assign req_idx  = req_addr[OFFSET_BITS +: INDEX_BITS];
    assign req_word = req_addr[3:2];

    assign hit_line = data_arr[in_idx];
    assign hit      = valid_bits[in_idx] && (tag_arr[in_idx] == in_tag);
    assign fill_en  = !rst && rdy && (state == MISS) && bus.ready_from_mem_ctrler;

    assign unused_addr_bits = ^{bus.addr_from_fetcher[1:0], req_addr[1:0]};

    // Tag/data storage carries no reset; only the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_arr[req_idx]  <= req_tag;
            data_arr[req_idx] <= bus.data_from_mem_ctrler;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                   <= IDLE;
            req_addr                <= '0;
            valid_bits              <= '0;
            bus.ready_to_fetcher    <= 1'b0;
            bus.inst_to_fetcher     <= '0;
            bus.valid_to_mem_ctrler <= 1'b0;
            bus.addr_to_mem_ctrler  <= '0;
        end else if (rdy) begin
            bus.ready_to_fetcher <= 1'b0;
            case (state)
                IDLE: begin
                    // While a pulse is out the fetcher has not yet dropped valid for that request.
                    if (!bus.ready_to_fetcher && bus.valid_from_fetcher) begin
                        req_addr <= bus.addr_from_fetcher;
                        if (hit) begin
                            bus.ready_to_fetcher <= 1'b1;
                            bus.inst_to_fetcher  <= hit_line[{in_word, 5'b0} +: 32];
                        end else begin
                            bus.valid_to_mem_ctrler <= 1'b1;
                            bus.addr_to_mem_ctrler  <= {in_tag, in_idx, {OFFSET_BITS{1'b0}}};
                            state                   <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (bus.ready_from_mem_ctrler) begin
                        valid_bits[req_idx]     <= 1'b1;
                        bus.valid_to_mem_ctrler <= 1'b0;
                        bus.ready_to_fetcher    <= 1'b1;
                        bus.inst_to_fetcher     <= bus.data_from_mem_ctrler[{req_word, 5'b0} +: 32];
                        state                   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - directed self-checking bench for icache
module tb_icache;
    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [127:0] LINE_A = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] LINE_B = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] LINE_C = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;

    icache_if bus ();

    icache dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.valid_from_fetcher    = 1'b0;
        bus.ready_from_mem_ctrler = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run_miss(input logic [31:0] a, input logic [127:0] line, input int lat,
                            input logic [31:0] exp_inst, input string nm);
        logic [31:0] exp_addr;
        exp_addr = {a[31:4], 4'b0};
        bus.valid_from_fetcher = 1'b1;
        bus.addr_from_fetcher  = a;
        step();
        n_checks++;
        if (bus.valid_to_mem_ctrler !== 1'b1 || bus.addr_to_mem_ctrler !== exp_addr || bus.ready_to_fetcher !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_req: valid=%b addr=%h ready=%b, want valid=1 addr=%h ready=0", nm,
                     bus.valid_to_mem_ctrler, bus.addr_to_mem_ctrler, bus.ready_to_fetcher, exp_addr);
        end
        bus.addr_from_fetcher = a ^ 32'h0000_0F0C;
        for (int i = 1; i < lat; i++) begin
            step();
            n_checks++;
            if (bus.valid_to_mem_ctrler !== 1'b1 || bus.addr_to_mem_ctrler !== exp_addr || bus.ready_to_fetcher !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_hold%0d: valid=%b addr=%h ready=%b, want valid=1 addr=%h ready=0", nm, i,
                         bus.valid_to_mem_ctrler, bus.addr_to_mem_ctrler, bus.ready_to_fetcher, exp_addr);
            end
        end
        bus.ready_from_mem_ctrler = 1'b1;
        bus.data_from_mem_ctrler  = line;
        step();
        bus.ready_from_mem_ctrler = 1'b0;
        bus.data_from_mem_ctrler  = '0;
        bus.valid_from_fetcher    = 1'b0;
        n_checks++;
        if (bus.ready_to_fetcher !== 1'b1 || bus.inst_to_fetcher !== exp_inst || bus.valid_to_mem_ctrler !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_resp: ready=%b inst=%h valid_mem=%b, want ready=1 inst=%h valid_mem=0", nm,
                     bus.ready_to_fetcher, bus.inst_to_fetcher, bus.valid_to_mem_ctrler, exp_inst);
        end
        step();
        n_checks++;
        if (bus.ready_to_fetcher !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_pulse_end: ready=%b, want 0", nm, bus.ready_to_fetcher);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({bus.ready_to_fetcher, bus.valid_to_mem_ctrler} !== 2'b00 || bus.inst_to_fetcher !== 32'h0 ||
            bus.addr_to_mem_ctrler !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: ready=%b valid_mem=%b inst=%h addr_mem=%h, want all 0",
                     bus.ready_to_fetcher, bus.valid_to_mem_ctrler, bus.inst_to_fetcher, bus.addr_to_mem_ctrler);
        end
    endtask

    task automatic test_first_miss();
        run_miss(32'h0000_1004, LINE_A, 3, 32'hBBBBBBBB, "miss1004");
    endtask

    task automatic test_hit();
        bus.valid_from_fetcher = 1'b1;
        bus.addr_from_fetcher  = 32'h0000_1008;
        step();
        bus.valid_from_fetcher = 1'b0;
        n_checks++;
        if (bus.ready_to_fetcher !== 1'b1 || bus.inst_to_fetcher !== 32'hCCCCCCCC || bus.valid_to_mem_ctrler !== 1'b0) begin
            n_fail++;
            $display("FAIL hit1008: ready=%b inst=%h valid_mem=%b, want ready=1 inst=cccccccc valid_mem=0",
                     bus.ready_to_fetcher, bus.inst_to_fetcher, bus.valid_to_mem_ctrler);
        end
        step();
        n_checks++;
        if (bus.ready_to_fetcher !== 1'b0 || bus.valid_to_mem_ctrler !== 1'b0) begin
            n_fail++;
            $display("FAIL hit1008_after: ready=%b valid_mem=%b, want 0 0", bus.ready_to_fetcher, bus.valid_to_mem_ctrler);
        end
    endtask

    task automatic test_conflict();
        run_miss(32'h0000_1400, LINE_B, 2, 32'h44444444, "conf1400");
        run_miss(32'h0000_1004, LINE_A, 1, 32'hBBBBBBBB, "conf1004");
    endtask

    task automatic test_rdy_freeze();
        int pulses;
        pulses = 0;
        bus.valid_from_fetcher = 1'b1;
        bus.addr_from_fetcher  = 32'h0000_2008;
        step();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (bus.valid_to_mem_ctrler !== 1'b1 || bus.addr_to_mem_ctrler !== 32'h0000_2000 || bus.ready_to_fetcher !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze_miss%0d: valid=%b addr=%h ready=%b, want 1 00002000 0", i,
                         bus.valid_to_mem_ctrler, bus.addr_to_mem_ctrler, bus.ready_to_fetcher);
            end
        end
        rdy = 1'b1;
        bus.ready_from_mem_ctrler = 1'b1;
        bus.data_from_mem_ctrler  = LINE_C;
        step();
        bus.ready_from_mem_ctrler = 1'b0;
        if (bus.ready_to_fetcher === 1'b1) pulses++;
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (bus.ready_to_fetcher !== 1'b1 || bus.inst_to_fetcher !== 32'h0C0C0C0C) begin
                n_fail++;
                $display("FAIL freeze_resp%0d: ready=%b inst=%h, want 1 0c0c0c0c", i,
                         bus.ready_to_fetcher, bus.inst_to_fetcher);
            end
        end
        rdy = 1'b1;
        bus.addr_from_fetcher = 32'h0000_200C;
        step();
        if (bus.ready_to_fetcher === 1'b1) pulses++;
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL freeze_one_resp: responses=%0d, want 1", pulses);
        end
        step();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++;
            if (bus.ready_to_fetcher !== 1'b1 || bus.inst_to_fetcher !== 32'h0D0D0D0D) begin
                n_fail++;
                $display("FAIL freeze_hit%0d: ready=%b inst=%h, want 1 0d0d0d0d", i,
                         bus.ready_to_fetcher, bus.inst_to_fetcher);
            end
        end
        rdy = 1'b1;
        bus.valid_from_fetcher = 1'b0;
        step();
        n_checks++;
        if (bus.ready_to_fetcher !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_hit_end: ready=%b, want 0", bus.ready_to_fetcher);
        end
    endtask

    task automatic test_reset_mid_miss();
        bus.valid_from_fetcher = 1'b1;
        bus.addr_from_fetcher  = 32'h0000_3004;
        step();
        step();
        step();
        rst = 1'b1;
        bus.valid_from_fetcher = 1'b0;
        step();
        rst = 1'b0;
        n_checks++;
        if (bus.valid_to_mem_ctrler !== 1'b0 || bus.ready_to_fetcher !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_miss: valid_mem=%b ready=%b, want 0 0", bus.valid_to_mem_ctrler, bus.ready_to_fetcher);
        end
        step();
        run_miss(32'h0000_1004, LINE_A, 2, 32'hBBBBBBBB, "refetch1004");
    endtask

    task automatic test_back_to_back();
        logic [3:0] seen;
        logic [3:0] want;
        want = 4'b0101;
        bus.ready_from_mem_ctrler = 1'b1;
        bus.data_from_mem_ctrler  = LINE_B;
        step();
        bus.ready_from_mem_ctrler = 1'b0;
        n_checks++;
        if (bus.ready_to_fetcher !== 1'b0 || bus.valid_to_mem_ctrler !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_mem_ready: ready=%b valid_mem=%b, want 0 0", bus.ready_to_fetcher, bus.valid_to_mem_ctrler);
        end
        bus.valid_from_fetcher = 1'b1;
        bus.addr_from_fetcher  = 32'h0000_1000;
        step();
        seen[0] = bus.ready_to_fetcher;
        n_checks++;
        if (bus.inst_to_fetcher !== 32'hAAAAAAAA) begin
            n_fail++;
            $display("FAIL b2b_first: inst=%h, want aaaaaaaa", bus.inst_to_fetcher);
        end
        bus.addr_from_fetcher = 32'h0000_1008;
        step();
        seen[1] = bus.ready_to_fetcher;
        step();
        seen[2] = bus.ready_to_fetcher;
        n_checks++;
        if (bus.inst_to_fetcher !== 32'hCCCCCCCC) begin
            n_fail++;
            $display("FAIL b2b_second: inst=%h, want cccccccc", bus.inst_to_fetcher);
        end
        bus.valid_from_fetcher = 1'b0;
        step();
        seen[3] = bus.ready_to_fetcher;
        n_checks++;
        if (seen !== want || bus.valid_to_mem_ctrler !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_pulses: pulses=%b valid_mem=%b, want %b 0", seen, bus.valid_to_mem_ctrler, want);
        end
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.valid_from_fetcher    = 1'b0;
        bus.addr_from_fetcher     = '0;
        bus.ready_from_mem_ctrler = 1'b0;
        bus.data_from_mem_ctrler  = '0;
        test_reset();
        test_first_miss();
        test_hit();
        test_conflict();
        test_rdy_freeze();
        test_reset_mid_miss();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
